// File: rtl/pedestrian_request_if.sv
// Pedestrian button / controller handshake bundle.
// The controller side is the master; the conditioner is the slave.
interface pedestrian_request_if;
  logic       btn_raw;
  logic       ack;
  logic       bt;
  logic       tick;
  logic [7:0] press_cnt;

  modport master (output btn_raw, ack, input bt, tick, press_cnt);
  modport slave  (input btn_raw, ack, output bt, tick, press_cnt);
endinterface

// File: rtl/pedestrian_request.sv
// Pedestrian push-button conditioner: sync + debounce, latched request with
// ack/hold-off handshake, free-running tick strobe, saturating press counter.
module pedestrian_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10,
  parameter int HOLDOFF_TICKS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  pedestrian_request_if.slave pif
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int TKW = $clog2(TICK_DIV);
  localparam int HOW = $clog2(HOLDOFF_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_DIV - 1);
  localparam logic [HOW-1:0] HO_LAST = HOW'(HOLDOFF_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PENDING, HOLDOFF} state_t;

  logic           s1, s2, stable, press;
  logic [DBW-1:0] db_cnt;
  logic [TKW-1:0] tick_cnt;
  logic           tick_q;
  state_t         state_q, state_d;
  logic           bt_q, bt_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [HOW-1:0] ho_cnt, ho_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= pif.btn_raw;
      s2 <= s1;
      if (s2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Only the rising update of the debounced level is a request event.
  assign press = s2 & ~stable & (db_cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q   <= (tick_cnt == TK_LAST);
      tick_cnt <= (tick_cnt == TK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bt_q    <= 1'b0;
      cnt_q   <= '0;
      ho_cnt  <= '0;
    end else begin
      state_q <= state_d;
      bt_q    <= bt_d;
      cnt_q   <= cnt_d;
      ho_cnt  <= ho_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bt_d    = bt_q;
    cnt_d   = cnt_q;
    ho_d    = ho_cnt;
    case (state_q)
      IDLE: if (press) begin
        state_d = PENDING;
        bt_d    = 1'b1;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end
      PENDING: if (pif.ack) begin
        state_d = HOLDOFF;
        bt_d    = 1'b0;
        ho_d    = '0;
      end
      HOLDOFF: if (tick_q) begin
        ho_d = ho_cnt + 1'b1;
        if (ho_cnt == HO_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pif.bt        = bt_q;
  assign pif.tick      = tick_q;
  assign pif.press_cnt = cnt_q;
endmodule
